// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   rq_q, rq_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 dbz_q, dbz_d;

  logic [2*WIDTH-1:0]   rq_shift;
  logic [WIDTH:0]       trial;

  // Shift the combined register and trial-subtract the divisor from its upper half.
  // The partial remainder never exceeds WIDTH-1 significant bits before a shift,
  // so the bit shifted out of the top is always zero and WIDTH+1 bits suffice.
  assign rq_shift = {rq_q[2*WIDTH-2:0], 1'b0};
  assign trial    = {1'b0, rq_shift[2*WIDTH-1:WIDTH]} - {1'b0, dvs_q};

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rq_q    <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rq_q    <= rq_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: accept start in IDLE/DONE, iterate in RUN, hold the result in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rq_d    = rq_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide by zero finishes at once: all-ones quotient, dividend as remainder.
            state_d = S_DONE;
            rq_d    = {dividend, {WIDTH{1'b1}}};
            dvs_d   = divisor;
            dbz_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_RUN;
            rq_d    = {{WIDTH{1'b0}}, dividend};
            dvs_d   = divisor;
            dbz_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      S_RUN: begin
        if (trial[WIDTH] == 1'b0) begin
          rq_d = {trial[WIDTH-1:0], rq_shift[WIDTH-1:1], 1'b1};
        end else begin
          rq_d = rq_shift;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registers; the result is only presented while ready.
  always_comb begin
    busy        = (state_q == S_RUN);
    ready       = (state_q == S_DONE);
    quotient    = ready ? rq_q[WIDTH-1:0] : '0;
    remainder   = ready ? rq_q[2*WIDTH-1:WIDTH] : '0;
    div_by_zero = ready & dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors;
  int miscompares;

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .ready       (ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge (edge N), then return 1ns after it.
  task automatic pulse_start(input logic [31:0] dd, input logic [31:0] ds);
    @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = dd;
    divisor  = ds;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0BAD_F00D;
  endtask

  // Wait for ready, counting edges since edge N and cycles with busy high.
  task automatic wait_ready(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = 0;
    while (!ready && lat < 100) begin
      if (busy) bcnt++;
      vectors++;
      assert (!(busy && ready)) else begin
        miscompares++;
        $error("FAIL busy_and_ready observed=1 expected=0");
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] dd, input logic [31:0] ds,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dbz, input int exp_lat);
    int lat;
    int bcnt;
    pulse_start(dd, ds);
    chk({tag, "_ready_after_accept"}, 32'(ready), (exp_lat == 0) ? 32'd1 : 32'd0);
    wait_ready(0, lat, bcnt);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_quotient"}, quotient, exp_q);
    chk({tag, "_remainder"}, remainder, exp_r);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
  endtask

  initial begin
    int lat;
    int bcnt;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    dividend    = '0;
    divisor     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
    run_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32);
    run_div("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 32);
    run_div("d0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 32);
    run_div("dmax_big", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 32);
    run_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    run_div("d1000_37", 32'd1000, 32'd37, 32'd27, 32'd1, 1'b0, 32);

    // Start during RUN is ignored: 100/7 runs to completion.
    pulse_start(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    chk("ignored_start_busy", 32'(busy), 32'd1);
    wait_ready(10, lat, bcnt);
    chk("ignored_start_latency", 32'(lat), 32'd32);
    chk("ignored_start_quotient", quotient, 32'd14);
    chk("ignored_start_remainder", remainder, 32'd2);
    // Fresh start from DONE.
    run_div("d50_5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 32);

    // Asynchronous reset mid-RUN.
    pulse_start(32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #3;
    chk("prereset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_ready", 32'(ready), 32'd0);
    chk("async_reset_quotient", quotient, 32'd0);
    chk("async_reset_remainder", remainder, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle_busy", 32'(busy), 32'd0);
    chk("post_reset_idle_ready", 32'(ready), 32'd0);
    run_div("d9_4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
